branch_resolve_ctrl: RTL and testbench

Sequences branch resolution between the fetch-stage predictor and the ALU stage. Records every predicted branch in a small in-flight queue and pops it when the branch resolves in ALU. On a mispredict it issues a flush window and a redirect PC. It also drives the predictor's counter update and keeps hit/miss statistics.

---
 rtl/branch_resolve_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: tracks predicted branches in flight, resolves them
// against the ALU outcome, and drives redirect/flush, predictor update and statistics.
module branch_resolve_ctrl #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int QUEUE_DEPTH   = 4,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_IF_valid,
  input  logic                     i_IF_isbranch,
  input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
  input  logic                     i_IF_taken,
  input  logic                     i_ALU_valid,
  input  logic                     i_ALU_isbranch,
  input  logic                     i_ALU_outcome,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
  output logic                     o_stall,
  output logic                     o_flush,
  output logic                     o_redirect_valid,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
  output logic                     o_upd_valid,
  output logic [ADDRESS_WIDTH-1:0] o_upd_pc,
  output logic                     o_upd_prediction,
  output logic                     o_upd_outcome,
  output logic [CNT_WIDTH-1:0]     o_branch_count,
  output logic [CNT_WIDTH-1:0]     o_mispredict_count,
  output logic                     o_err
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                     state, next_state;
  logic [3:0]                 flush_left;
  logic [ADDRESS_WIDTH-1:0]   pc_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]     tk_q;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [OCC_W-1:0]           count;

  logic                       run, pop, push, mispredict, empty_resolve;
  logic [ADDRESS_WIDTH-1:0]   head_pc;
  logic                       head_tk;

  assign run           = (state == RUN);
  assign head_pc       = pc_q[rd_ptr];
  assign head_tk       = tk_q[rd_ptr];
  assign pop           = run & i_ALU_valid & i_ALU_isbranch & (count != '0);
  assign empty_resolve = run & i_ALU_valid & i_ALU_isbranch & (count == '0);
  assign o_stall       = (count == OCC_W'(QUEUE_DEPTH)) & ~pop;
  assign push          = run & i_IF_valid & i_IF_isbranch & ~o_stall;
  assign mispredict    = pop & (head_tk != i_ALU_outcome);
  assign o_flush       = (state == FLUSH);

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mispredict) next_state = FLUSH;
      FLUSH:   if (flush_left == 4'd1) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      state <= next_state;
      if (mispredict)
        flush_left <= 4'(FLUSH_CYCLES);
      else if (state == FLUSH)
        flush_left <= flush_left - 4'd1;
    end
  end

  // A mispredict empties the queue and wins over any same-cycle push.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) pc_q[i] <= '0;
      tk_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr] <= i_IF_pc;
        tk_q[wr_ptr] <= i_IF_taken;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + OCC_W'(1);
      else if (pop && !push)
        count <= count - OCC_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_upd_valid        <= 1'b0;
      o_upd_pc           <= '0;
      o_upd_prediction   <= 1'b0;
      o_upd_outcome      <= 1'b0;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= '0;
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
      o_err              <= 1'b0;
    end else begin
      o_upd_valid      <= pop;
      o_redirect_valid <= mispredict;
      if (pop) begin
        o_upd_pc         <= head_pc;
        o_upd_prediction <= head_tk;
        o_upd_outcome    <= i_ALU_outcome;
        if (o_branch_count != '1)
          o_branch_count <= o_branch_count + CNT_WIDTH'(1);
      end
      if (mispredict) begin
        o_redirect_pc <= i_ALU_outcome ? i_ALU_target : head_pc + ADDRESS_WIDTH'(1);
        if (o_mispredict_count != '1)
          o_mispredict_count <= o_mispredict_count + CNT_WIDTH'(1);
      end
      if (empty_resolve)
        o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int AW = 22;
  localparam int QD = 4;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid = 1'b0, if_isbranch = 1'b0, if_taken = 1'b0;
  logic [AW-1:0] if_pc = '0;
  logic          alu_valid = 1'b0, alu_isbranch = 1'b0, alu_outcome = 1'b0;
  logic [AW-1:0] alu_target = '0;
  logic          stall, flush, redirect_valid, upd_valid, upd_prediction, upd_outcome, err;
  logic [AW-1:0] redirect_pc, upd_pc;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolve_ctrl #(.ADDRESS_WIDTH(AW), .QUEUE_DEPTH(QD), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_IF_valid(if_valid), .i_IF_isbranch(if_isbranch), .i_IF_pc(if_pc), .i_IF_taken(if_taken),
    .i_ALU_valid(alu_valid), .i_ALU_isbranch(alu_isbranch), .i_ALU_outcome(alu_outcome),
    .i_ALU_target(alu_target),
    .o_stall(stall), .o_flush(flush), .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_upd_valid(upd_valid), .o_upd_pc(upd_pc), .o_upd_prediction(upd_prediction),
    .o_upd_outcome(upd_outcome), .o_branch_count(branch_count),
    .o_mispredict_count(mispredict_count), .o_err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight branches as a FIFO queue, flush as a cycles-remaining count.
  typedef struct { logic [AW-1:0] pc; logic tk; } ent_t;
  ent_t          mq[$];
  int            m_flush_left, m_bc, m_mc;
  logic          m_err, m_upd_v, m_pred, m_out, m_rv;
  logic [AW-1:0] m_upd_pc, m_rpc;
  logic          stall_seen;

  task automatic model_reset();
    mq.delete();
    m_flush_left = 0; m_bc = 0; m_mc = 0;
    m_err = 0; m_upd_v = 0; m_pred = 0; m_out = 0; m_rv = 0;
    m_upd_pc = '0; m_rpc = '0;
  endtask

  task automatic cycle(input logic iv, input logic ib, input logic [AW-1:0] ipc, input logic itk,
                       input logic av, input logic ab, input logic aout, input logic [AW-1:0] atgt);
    bit   run, pop, exp_stall, push, mis;
    ent_t e;
    if_valid = iv; if_isbranch = ib; if_pc = ipc; if_taken = itk;
    alu_valid = av; alu_isbranch = ab; alu_outcome = aout; alu_target = atgt;
    run       = (m_flush_left == 0);
    pop       = run && av && ab && (mq.size() != 0);
    exp_stall = (mq.size() == QD) && !pop;
    push      = run && iv && ib && !exp_stall;
    #3;
    stall_seen = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    m_upd_v = 0; m_rv = 0; mis = 0;
    if (!run) m_flush_left--;
    if (run && av && ab && mq.size() == 0) m_err = 1;
    if (pop) begin
      e = mq.pop_front();
      m_upd_v = 1; m_upd_pc = e.pc; m_pred = e.tk; m_out = aout;
      if (m_bc < CMAX) m_bc++;
      if (e.tk != aout) begin
        mis = 1; m_rv = 1;
        m_rpc = aout ? atgt : e.pc + AW'(1);
        if (m_mc < CMAX) m_mc++;
        mq.delete();
        m_flush_left = FC;
      end
    end
    if (push && !mis) mq.push_back('{pc: ipc, tk: itk});
    @(posedge clk); #1;
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("upd_valid", 32'(upd_valid), 32'(m_upd_v));
    chk("upd_pc", 32'(upd_pc), 32'(m_upd_pc));
    chk("upd_prediction", 32'(upd_prediction), 32'(m_pred));
    chk("upd_outcome", 32'(upd_outcome), 32'(m_out));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic iv, ib; logic [AW-1:0] ipc; logic itk;
    logic av, ab, aout; logic [AW-1:0] atgt;
    logic e_uv; logic [AW-1:0] e_upc; logic e_pred, e_out;
    logic e_rv; logic [AW-1:0] e_rpc; logic e_flush;
    int   e_bc, e_mc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    model_reset();
    vecs[0]  = '{1'b1,1'b1,22'h10,1'b1,     1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   0,0};
    vecs[1]  = '{1'b0,1'b0,22'h0,1'b0,      1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   0,0};
    vecs[2]  = '{1'b0,1'b0,22'h0,1'b0,      1'b1,1'b1,1'b1,22'h0,   1'b1,22'h10,1'b1,1'b1,    1'b0,22'h0,1'b0,   1,0};
    vecs[3]  = '{1'b1,1'b1,22'h20,1'b0,     1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   1,0};
    vecs[4]  = '{1'b0,1'b0,22'h0,1'b0,      1'b1,1'b1,1'b1,22'h100, 1'b1,22'h20,1'b0,1'b1,    1'b1,22'h100,1'b1, 2,1};
    vecs[5]  = '{1'b0,1'b0,22'h0,1'b0,      1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b1,   2,1};
    vecs[6]  = '{1'b1,1'b1,22'h55,1'b1,     1'b1,1'b1,1'b0,22'h77,  1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   2,1};
    vecs[7]  = '{1'b1,1'b1,22'h3FFFFF,1'b1, 1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   2,1};
    vecs[8]  = '{1'b0,1'b0,22'h0,1'b0,      1'b1,1'b1,1'b0,22'h123, 1'b1,22'h3FFFFF,1'b1,1'b0,1'b1,22'h0,1'b1,   3,2};
    vecs[9]  = '{1'b0,1'b0,22'h0,1'b0,      1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b1,   3,2};
    vecs[10] = '{1'b0,1'b0,22'h0,1'b0,      1'b0,1'b0,1'b0,22'h0,   1'b0,22'h0,1'b0,1'b0,     1'b0,22'h0,1'b0,   3,2};

    // Reset state
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_branch_count", 32'(branch_count), 32'd0);
    chk("rst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table: correct prediction, NT->T mispredict with flush window, ignored
    // inputs during flush, T->NT mispredict at the address wrap edge.
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].iv, vecs[i].ib, vecs[i].ipc, vecs[i].itk,
            vecs[i].av, vecs[i].ab, vecs[i].aout, vecs[i].atgt);
      chk("tbl_upd_valid", 32'(upd_valid), 32'(vecs[i].e_uv));
      if (vecs[i].e_uv) begin
        chk("tbl_upd_pc", 32'(upd_pc), 32'(vecs[i].e_upc));
        chk("tbl_upd_prediction", 32'(upd_prediction), 32'(vecs[i].e_pred));
        chk("tbl_upd_outcome", 32'(upd_outcome), 32'(vecs[i].e_out));
      end
      chk("tbl_redirect_valid", 32'(redirect_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk("tbl_redirect_pc", 32'(redirect_pc), 32'(vecs[i].e_rpc));
      chk("tbl_flush", 32'(flush), 32'(vecs[i].e_flush));
      chk("tbl_branch_count", 32'(branch_count), 32'(vecs[i].e_bc));
      chk("tbl_mispredict_count", 32'(mispredict_count), 32'(vecs[i].e_mc));
      chk("tbl_err", 32'(err), 32'd0);
    end

    // Full queue: 4 pushes, rejected 5th, push+pop while full, then in-order drain
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 22'hA0 + AW'(i), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 22'hA4, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("full_stall", 32'(stall_seen), 32'd1);
    cycle(1'b1, 1'b1, 22'hA5, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("full_pushpop_stall", 32'(stall_seen), 32'd0);
    chk("full_pushpop_upd_pc", 32'(upd_pc), 32'hA0);
    cycle(1'b1, 1'b1, 22'hA6, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("still_full_stall", 32'(stall_seen), 32'd1);
    begin
      logic [AW-1:0] order [4];
      order[0] = 22'hA1; order[1] = 22'hA2; order[2] = 22'hA3; order[3] = 22'hA5;
      for (int i = 0; i < 4; i++) begin
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("drain_upd_valid", 32'(upd_valid), 32'd1);
        chk("drain_upd_pc", 32'(upd_pc), 32'(order[i]));
      end
    end

    // Resolve with empty queue: sticky error, no update
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 22'h9);
    chk("empty_err", 32'(err), 32'd1);
    chk("empty_no_upd", 32'(upd_valid), 32'd0);
    idle(); idle();
    chk("err_sticky", 32'(err), 32'd1);

    // Saturation of the branch counter
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 22'h200 + AW'(i), 1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
    end
    chk("branch_count_sat", 32'(branch_count), 32'd15);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom));
    end

    // Async reset in the middle of a flush window
    idle(); idle(); idle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 22'h300 + AW'(i), 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("pre_reset_flush", 32'(flush), 32'd1);
    alu_valid = 1'b0; alu_isbranch = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flush", 32'(flush), 32'd0);
    chk("async_rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("async_rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("async_rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("async_rst_upd_pc", 32'(upd_pc), 32'd0);
    chk("async_rst_branch_count", 32'(branch_count), 32'd0);
    chk("async_rst_mispredict_count", 32'(mispredict_count), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
    chk("post_reset_no_upd", 32'(upd_valid), 32'd0);
    chk("post_reset_empty_err", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
